// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_pkg
//  Description : Shared state encoding, default widths and ALU opcodes for the
//                ALU/RAM sequencer and the ALU it drives.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_pkg;

    localparam int c_default_aw  = 8;
    localparam int c_default_dw  = 16;
    localparam int c_default_opw = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } seq_state_t;

    // Opcodes understood by the companion ALU
    localparam logic [c_default_opw-1:0] c_alu_add    = 5'd0;
    localparam logic [c_default_opw-1:0] c_alu_sub    = 5'd1;
    localparam logic [c_default_opw-1:0] c_alu_and    = 5'd2;
    localparam logic [c_default_opw-1:0] c_alu_or     = 5'd3;
    localparam logic [c_default_opw-1:0] c_alu_xor    = 5'd4;
    localparam logic [c_default_opw-1:0] c_alu_pass_a = 5'd5;

endpackage
`default_nettype wire

// File: rtl/seq_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : seq_addr_gen
//  Description : Pointer / remaining-step tracker for the sequencer; produces
//                ptr, ptr+1, ptr+2 (mod 2^AW) and the last-step flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_addr_gen #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic [AW-1:0] i_base,
    input  logic [AW-1:0] i_count,
    input  logic          i_step,
    output logic [AW-1:0] o_ptr,
    output logic [AW-1:0] o_ptr_p1,
    output logic [AW-1:0] o_ptr_p2,
    output logic          o_last
);

    localparam logic [AW-1:0] c_one = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] c_two = c_one + c_one;

    logic [AW-1:0] r_ptr;
    logic [AW-1:0] r_rem;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= '0;
            r_rem <= '0;
        end else if (i_load) begin
            r_ptr <= i_base;
            r_rem <= i_count;
        end else if (i_step) begin
            r_ptr <= r_ptr + c_one;
            r_rem <= r_rem - c_one;
        end
    end

    assign o_ptr    = r_ptr;
    assign o_ptr_p1 = r_ptr + c_one;
    assign o_ptr_p2 = r_ptr + c_two;
    // Flag is evaluated before the decrement, so rem==1 means this WRITE is the final one
    assign o_last   = (r_rem == c_one);

endmodule
`default_nettype wire

// File: rtl/alu_ram_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_ram_sequencer
//  Description : Drives the ALU/dual-port RAM datapath to evaluate
//                mem[p+2] = ALU(mem[p], mem[p+1], op) for count steps.
//                Optional macro SEQ_CYCLE_CNT_EN adds a 16-bit busy-cycle counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_ram_sequencer
    import seq_pkg::*;
#(
    parameter int AW     = c_default_aw,
    parameter int DW     = c_default_dw,
    parameter int OPW    = c_default_opw,
    parameter int RD_LAT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [AW-1:0]  base,
    input  logic [AW-1:0]  count,
    input  logic [OPW-1:0] op,
    output logic           busy,
    output logic           done,
    output logic [AW-1:0]  addra,
    output logic           wea,
    output logic [DW-1:0]  dina,
    input  logic [DW-1:0]  douta,
    output logic [AW-1:0]  addrb,
    input  logic [DW-1:0]  doutb,
    output logic [DW-1:0]  alu_a,
    output logic [DW-1:0]  alu_b,
    output logic [OPW-1:0] alu_op,
    input  logic [DW-1:0]  alu_result
`ifdef SEQ_CYCLE_CNT_EN
    ,
    output logic [15:0]    cycles
`endif
);

    localparam int c_wait_w = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [c_wait_w-1:0] c_wait_init = c_wait_w'(RD_LAT - 1);

    seq_state_t          r_state;
    seq_state_t          w_state_next;
    logic [c_wait_w-1:0] r_wait_cnt;
    logic [OPW-1:0]      r_op_lat;
    logic [DW-1:0]       r_alu_a;
    logic [DW-1:0]       r_alu_b;
    logic [OPW-1:0]      r_alu_op;
    logic                r_done;

    logic                w_accept;
    logic                w_load;
    logic                w_step;
    logic [AW-1:0]       w_ptr;
    logic [AW-1:0]       w_ptr_p1;
    logic [AW-1:0]       w_ptr_p2;
    logic                w_last;

    assign w_accept = (r_state == ST_IDLE) && start;
    assign w_load   = w_accept && (count != '0);
    assign w_step   = (r_state == ST_WRITE);

    seq_addr_gen #(
        .AW (AW)
    ) u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_load),
        .i_base   (base),
        .i_count  (count),
        .i_step   (w_step),
        .o_ptr    (w_ptr),
        .o_ptr_p1 (w_ptr_p1),
        .o_ptr_p2 (w_ptr_p2),
        .o_last   (w_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
            r_op_lat   <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= (r_state == ST_DONE);
            if (w_load) begin
                r_op_lat <= op;
            end
            if (r_state == ST_READ) begin
                r_wait_cnt <= c_wait_init;
            end else if (r_state == ST_WAIT && r_wait_cnt != '0) begin
                r_wait_cnt <= r_wait_cnt - 1'b1;
            end
            if (r_state == ST_EXEC) begin
                r_alu_a  <= douta;
                r_alu_b  <= doutb;
                r_alu_op <= r_op_lat;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = (count != '0) ? ST_READ : ST_DONE;
                end
            end
            ST_READ:  w_state_next = ST_WAIT;
            ST_WAIT: begin
                if (r_wait_cnt == '0) begin
                    w_state_next = ST_EXEC;
                end
            end
            ST_EXEC:  w_state_next = ST_WRITE;
            ST_WRITE: w_state_next = w_last ? ST_DONE : ST_READ;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Read addresses stay up through EXEC so douta/doutb are still valid when captured
    always_comb begin
        addra = '0;
        addrb = '0;
        dina  = '0;
        case (r_state)
            ST_READ, ST_WAIT, ST_EXEC: begin
                addra = w_ptr;
                addrb = w_ptr_p1;
            end
            ST_WRITE: begin
                addra = w_ptr_p2;
                dina  = alu_result;
            end
            default: ;
        endcase
    end

    // Gating with rst_n drops a write whose edge coincides with reset
    assign wea    = (r_state == ST_WRITE) && rst_n;
    assign busy   = (r_state != ST_IDLE);
    assign done   = r_done;
    assign alu_a  = r_alu_a;
    assign alu_b  = r_alu_b;
    assign alu_op = r_alu_op;

`ifdef SEQ_CYCLE_CNT_EN
    logic [15:0] r_cycles;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cycles <= '0;
        end else if (w_accept) begin
            r_cycles <= '0;
        end else if (busy && r_cycles != 16'hFFFF) begin
            r_cycles <= r_cycles + 16'd1;
        end
    end

    assign cycles = r_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_ram_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_ram_sequencer
//  Description : Self-checking bench for alu_ram_sequencer with a behavioural
//                dual-port RAM, ALU model and write scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_ram_sequencer;
    import seq_pkg::*;

    localparam int AW  = 8;
    localparam int DW  = 16;
    localparam int OPW = 5;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [AW-1:0]  base;
    logic [AW-1:0]  count;
    logic [OPW-1:0] op;
    logic           busy;
    logic           done;
    logic [AW-1:0]  addra;
    logic           wea;
    logic [DW-1:0]  dina;
    logic [DW-1:0]  douta;
    logic [AW-1:0]  addrb;
    logic [DW-1:0]  doutb;
    logic [DW-1:0]  alu_a;
    logic [DW-1:0]  alu_b;
    logic [OPW-1:0] alu_op;
    logic [DW-1:0]  alu_result;
`ifdef SEQ_CYCLE_CNT_EN
    logic [15:0]    cycles;
`endif

    logic [DW-1:0]  mem [256];
    wr_t            sb_q [$];
    int             n_checks = 0;
    int             n_fail   = 0;
    int             n_wea    = 0;
    int             n_done   = 0;

    always #5 clk = ~clk;

    alu_ram_sequencer #(
        .AW     (AW),
        .DW     (DW),
        .OPW    (OPW),
        .RD_LAT (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base       (base),
        .count      (count),
        .op         (op),
        .busy       (busy),
        .done       (done),
        .addra      (addra),
        .wea        (wea),
        .dina       (dina),
        .douta      (douta),
        .addrb      (addrb),
        .doutb      (doutb),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result)
`ifdef SEQ_CYCLE_CNT_EN
        ,
        .cycles     (cycles)
`endif
    );

    function automatic logic [DW-1:0] alu_model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                                input logic [OPW-1:0] o);
        case (o)
            c_alu_add: return a + b;
            c_alu_sub: return a - b;
            c_alu_and: return a & b;
            c_alu_or:  return a | b;
            c_alu_xor: return a ^ b;
            default:   return a;
        endcase
    endfunction

    assign alu_result = alu_model(alu_a, alu_b, alu_op);

    // Synchronous dual-port RAM, one-cycle read latency, port B read-only
    always @(posedge clk) begin
        if (wea) mem[addra] <= dina;
        douta <= mem[addra];
        doutb <= mem[addrb];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) n_done++;
        if (wea === 1'b1) begin
            n_wea++;
            chk("sb_write_expected", (sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                wr_t e;
                e = sb_q.pop_front();
                chk("sb_write_addr_data", {8'h00, addra, dina}, {8'h00, e});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: replay the recurrence on a copy of memory, queue each write
    task automatic model_push(input logic [AW-1:0] b, input int c, input logic [OPW-1:0] o);
        logic [DW-1:0] m [256];
        logic [AW-1:0] p;
        wr_t           e;
        m = mem;
        for (int i = 0; i < c; i++) begin
            p      = b + AW'(i);
            e.addr = p + 8'd2;
            e.data = alu_model(m[p], m[p + 8'd1], o);
            m[e.addr] = e.data;
            sb_q.push_back(e);
        end
    endtask

    task automatic run_start(input logic [AW-1:0] b, input logic [AW-1:0] c, input logic [OPW-1:0] o);
        start = 1'b1;
        base  = b;
        count = c;
        op    = o;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int lat;
        lat = 0;
        for (int k = 1; k <= 200; k++) begin
            tick();
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
        chk(tag, lat, exp_lat);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] <= '0;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int d0;
        rst_n = 1'b0;
        start = 1'b0;
        base  = '0;
        count = '0;
        op    = '0;
        repeat (3) tick();

        chk("rst_busy_done_wea", {busy, done, wea}, 0);
        chk("rst_addr", {addra, addrb}, 0);
        chk("rst_dina_alu_a", {dina, alu_a}, 0);
        chk("rst_alu_b_op", {alu_b, alu_op}, 0);
`ifdef SEQ_CYCLE_CNT_EN
        chk("rst_cycles", cycles, 0);
`endif
        rst_n = 1'b1;
        tick();

        // Fibonacci
        mem[0] <= 16'd1;
        mem[1] <= 16'd1;
        tick();
        w0 = n_wea;
        model_push(8'h00, 5, c_alu_add);
        run_start(8'h00, 8'd5, c_alu_add);
        chk("fib_busy_after_accept", busy, 1);
        wait_done("fib_done_latency", 21);
        chk("fib_busy_low_at_done", busy, 0);
        chk("fib_wea_pulses", n_wea - w0, 5);
        chk("fib_mem2", mem[2], 16'd2);
        chk("fib_mem3", mem[3], 16'd3);
        chk("fib_mem4", mem[4], 16'd5);
        chk("fib_mem5", mem[5], 16'd8);
        chk("fib_mem6", mem[6], 16'd13);
        chk("fib_sb_empty", sb_q.size(), 0);
`ifdef SEQ_CYCLE_CNT_EN
        chk("fib_cycles", cycles, 21);
`endif
        tick();
        chk("fib_done_one_cycle", done, 0);
        repeat (3) tick();
        chk("idle_alu_op_hold", alu_op, c_alu_add);
`ifdef SEQ_CYCLE_CNT_EN
        chk("fib_cycles_held", cycles, 21);
`endif

        // Wrap-around at the top of the address space
        mem[8'hFE] <= 16'd7;
        mem[8'hFF] <= 16'd9;
        tick();
        w0 = n_wea;
        model_push(8'hFE, 1, c_alu_add);
        run_start(8'hFE, 8'd1, c_alu_add);
        chk("wrap_read_addrs", {addra, addrb}, 16'hFEFF);
`ifdef SEQ_CYCLE_CNT_EN
        chk("cycles_cleared_on_start", cycles, 0);
`endif
        wait_done("wrap_done_latency", 5);
        chk("wrap_wea_pulses", n_wea - w0, 1);
        chk("wrap_mem0", mem[0], 16'd16);
        chk("wrap_sb_empty", sb_q.size(), 0);
        tick();

        // Zero count
        w0 = n_wea;
        run_start(8'h33, 8'd0, c_alu_add);
        chk("zero_busy_done_first", {busy, done}, 2'b10);
        tick();
        chk("zero_busy_done_second", {busy, done}, 2'b01);
        tick();
        chk("zero_no_write", n_wea - w0, 0);

        // Start while busy is ignored
        mem[8'h10] <= 16'd3;
        mem[8'h11] <= 16'd4;
        tick();
        d0 = n_done;
        model_push(8'h10, 3, c_alu_xor);
        run_start(8'h10, 8'd3, c_alu_xor);
        repeat (5) tick();
        start = 1'b1;
        base  = 8'h40;
        count = 8'd2;
        op    = c_alu_add;
        tick();
        start = 1'b0;
        wait_done("busy_start_done_latency", 7);
        repeat (3) tick();
        chk("busy_start_single_done", n_done - d0, 1);
        chk("busy_start_sb_empty", sb_q.size(), 0);
        chk("busy_start_mem14", mem[8'h14], 16'd4);

        // Reset during WRITE of step 3
        mem[4] <= 16'hDEAD;
        tick();
        model_push(8'h00, 2, c_alu_add);
        run_start(8'h00, 8'd5, c_alu_add);
        repeat (11) tick();
        chk("midrst_in_write_addr", addra, 8'h04);
        rst_n = 1'b0;
        tick();
        chk("midrst_busy_done_wea", {busy, done, wea}, 0);
        chk("midrst_addr", {addra, addrb}, 0);
        chk("midrst_dina_alu_a", {dina, alu_a}, 0);
        chk("midrst_alu_b_op", {alu_b, alu_op}, 0);
        chk("midrst_mem4_kept", mem[4], 16'hDEAD);
        chk("midrst_sb_empty", sb_q.size(), 0);
        rst_n = 1'b1;
        mem[8'h20] <= 16'h00F0;
        mem[8'h21] <= 16'h000F;
        tick();
        model_push(8'h20, 1, c_alu_or);
        run_start(8'h20, 8'd1, c_alu_or);
        wait_done("post_rst_done_latency", 5);
        chk("post_rst_mem22", mem[8'h22], 16'h00FF);
        chk("post_rst_sb_empty", sb_q.size(), 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
